// File: rtl/cond_logic.sv
// ARM condition-logic stage: owns NZCV, evaluates Cond, gates PC/reg/mem/flag writes.
// Define COND_CNT_EN to build the saturating executed/skipped instruction counters.
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CntClr,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic             CondUndef,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic [3:0] flags_q;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       ge;
    logic       commit;
    logic       take;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign ge     = (flag_n == flag_v);
    assign commit = Valid & ~Stall;
    assign take   = commit & CondEx;

    // Condition is evaluated against the registered flags only, so a flag
    // update by this instruction is first seen by the next one.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flag_z;
            4'b0001: CondEx = ~flag_z;
            4'b0010: CondEx = flag_c;
            4'b0011: CondEx = ~flag_c;
            4'b0100: CondEx = flag_n;
            4'b0101: CondEx = ~flag_n;
            4'b0110: CondEx = flag_v;
            4'b0111: CondEx = ~flag_v;
            4'b1000: CondEx = flag_c & ~flag_z;
            4'b1001: CondEx = ~(flag_c & ~flag_z);
            4'b1010: CondEx = ge;
            4'b1011: CondEx = ~ge;
            4'b1100: CondEx = ~flag_z & ge;
            4'b1101: CondEx = ~(~flag_z & ge);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    assign CondUndef = Valid & (Cond == 4'b1111);
    assign PCSrc     = take & PCS;
    assign RegWrite  = take & RegW & ~NoWrite;
    assign MemWrite  = take & MemW;
    assign Flags     = flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (take) begin
            if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef COND_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] skip_q;

    // Clear wins over the increment of the instruction committing on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (CntClr) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (commit) begin
            if (CondEx) begin
                if (exec_q != CNT_MAX) exec_q <= exec_q + CNT_ONE;
            end else begin
                if (skip_q != CNT_MAX) skip_q <= skip_q + CNT_ONE;
            end
        end
    end

    assign ExecCount = exec_q;
    assign SkipCount = skip_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = CntClr;
    assign ExecCount      = '0;
    assign SkipCount      = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: constant-expectation vector table, a
// reference model for random and hand-written sequences, scoreboard queue.
module tb_cond_logic;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
`ifdef COND_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct packed {
        logic       valid;
        logic       stall;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowr;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic       condex;
        logic       undef;
        logic       pcsrc;
        logic       regwr;
        logic       memwr;
        logic [3:0] flags;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t r;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             Valid;
    logic             Stall;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CntClr;
    logic [3:0]       Flags;
    logic             CondEx;
    logic             CondUndef;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .CntClr(CntClr), .Flags(Flags), .CondEx(CondEx),
        .CondUndef(CondUndef), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [3:0]       mflags;
    logic [CNT_W-1:0] mexec;
    logic [CNT_W-1:0] mskip;
    resp_t            sb[$];
    vec_t             tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t model(input stim_t s);
        resp_t r;
        logic  n, z, c, v, ge, base, commit;
        {n, z, c, v} = mflags;
        ge = (n == v);
        case (s.cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = ge;
            3'd6:    base = ~z & ge;
            default: base = 1'b1;
        endcase
        commit   = s.valid & ~s.stall;
        r.condex = (s.cond == 4'hF) ? 1'b0 : (base ^ s.cond[0]);
        r.undef  = s.valid & (s.cond == 4'hF);
        r.pcsrc  = commit & r.condex & s.pcs;
        r.regwr  = commit & r.condex & s.regw & ~s.nowr;
        r.memwr  = commit & r.condex & s.memw;
        r.flags  = mflags;
        if (commit & r.condex) begin
            if (s.fw[1]) r.flags[3:2] = s.alu[3:2];
            if (s.fw[0]) r.flags[1:0] = s.alu[1:0];
        end
        return r;
    endfunction

    function automatic stim_t mks(input logic v, st, input logic [3:0] cond, alu,
                                  input logic [1:0] fw, input logic pcs, rw, mw, nw, clr);
        stim_t s;
        s = '{valid: v, stall: st, cond: cond, alu: alu, fw: fw,
              pcs: pcs, regw: rw, memw: mw, nowr: nw, clr: clr};
        return s;
    endfunction

    function automatic vec_t mk(input logic v, st, input logic [3:0] cond, alu,
                                input logic [1:0] fw, input logic pcs, rw, mw, nw,
                                input logic ex, un, pc, rwr, mwr, input logic [3:0] fl);
        vec_t t;
        t.s = mks(v, st, cond, alu, fw, pcs, rw, mw, nw, 1'b0);
        t.r = '{condex: ex, undef: un, pcsrc: pc, regwr: rwr, memwr: mwr, flags: fl};
        return t;
    endfunction

    task automatic apply(input stim_t s, input resp_t e);
        resp_t exp;
        @(negedge clk);
        Valid = s.valid; Stall = s.stall; Cond = s.cond; ALUFlags = s.alu;
        FlagW = s.fw; PCS = s.pcs; RegW = s.regw; MemW = s.memw;
        NoWrite = s.nowr; CntClr = s.clr;
        sb.push_back(e);
        n_vec++;
        #2;
        exp = sb.pop_front();
        check("cond_ex", {7'd0, CondEx}, {7'd0, exp.condex});
        check("cond_undef", {7'd0, CondUndef}, {7'd0, exp.undef});
        check("pc_src", {7'd0, PCSrc}, {7'd0, exp.pcsrc});
        check("reg_write", {7'd0, RegWrite}, {7'd0, exp.regwr});
        check("mem_write", {7'd0, MemWrite}, {7'd0, exp.memwr});
        if (CNT_ON) begin
            if (s.clr) begin
                mexec = '0;
                mskip = '0;
            end else if (s.valid && !s.stall) begin
                if (exp.condex) begin
                    if (mexec != CMAX) mexec = mexec + 1'b1;
                end else begin
                    if (mskip != CMAX) mskip = mskip + 1'b1;
                end
            end
        end
        mflags = exp.flags;
        @(posedge clk);
        #1;
        check("flags", {4'd0, Flags}, {4'd0, mflags});
        check("exec_count", 8'(ExecCount), 8'(mexec));
        check("skip_count", 8'(SkipCount), 8'(mskip));
    endtask

    task automatic apply_model(input stim_t s);
        apply(s, model(s));
    endtask

    initial begin
        stim_t s;
        reset = 1'b1; Valid = 0; Stall = 0; Cond = 0; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; CntClr = 0;
        mflags = '0; mexec = '0; mskip = '0;

        // Known-answer table, applied from Flags = 0000 right after reset.
        tbl.push_back(mk(1,0,4'hE,4'b0100,2'b11,0,0,0,0, 1,0,0,0,0, 4'b0100));
        tbl.push_back(mk(1,0,4'h0,4'b0000,2'b00,0,1,0,0, 1,0,0,1,0, 4'b0100));
        tbl.push_back(mk(1,0,4'h1,4'b1010,2'b11,1,0,1,0, 0,0,0,0,0, 4'b0100));
        tbl.push_back(mk(1,0,4'h0,4'b0000,2'b00,0,1,0,1, 1,0,0,0,0, 4'b0100));
        tbl.push_back(mk(1,0,4'hE,4'b0000,2'b11,0,0,0,0, 1,0,0,0,0, 4'b0000));
        tbl.push_back(mk(1,0,4'hE,4'b1111,2'b01,0,0,0,0, 1,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'hA,4'b0000,2'b00,1,0,0,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'hB,4'b0000,2'b00,1,0,0,0, 1,0,1,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h2,4'b0000,2'b00,0,0,1,0, 1,0,0,0,1, 4'b0011));
        tbl.push_back(mk(1,0,4'h3,4'b0000,2'b00,0,0,1,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h6,4'b0000,2'b00,0,1,0,0, 1,0,0,1,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h7,4'b0000,2'b00,0,1,0,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h8,4'b0000,2'b00,1,0,0,0, 1,0,1,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h9,4'b0000,2'b00,1,0,0,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'hC,4'b0000,2'b00,0,1,0,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'hD,4'b0000,2'b00,0,1,0,0, 1,0,0,1,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h4,4'b0000,2'b00,0,0,1,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h5,4'b0000,2'b00,0,0,1,0, 1,0,0,0,1, 4'b0011));
        tbl.push_back(mk(1,1,4'hE,4'b1000,2'b11,0,1,0,0, 1,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'hF,4'b1000,2'b11,0,1,0,0, 0,1,0,0,0, 4'b0011));
        tbl.push_back(mk(0,0,4'hF,4'b1000,2'b11,1,1,1,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(0,0,4'hE,4'b1000,2'b11,1,1,1,0, 1,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h0,4'b0100,2'b11,0,0,0,0, 0,0,0,0,0, 4'b0011));
        tbl.push_back(mk(1,0,4'h1,4'b1100,2'b10,0,0,0,0, 1,0,0,0,0, 4'b1111));
        tbl.push_back(mk(1,0,4'h0,4'b0000,2'b11,0,1,0,0, 1,0,0,1,0, 4'b0000));
        tbl.push_back(mk(1,0,4'h0,4'b0000,2'b00,0,1,0,0, 0,0,0,0,0, 4'b0000));
        tbl.push_back(mk(1,0,4'hC,4'b0000,2'b00,1,0,0,0, 1,0,1,0,0, 4'b0000));
        tbl.push_back(mk(1,0,4'h9,4'b0000,2'b00,1,0,0,0, 1,0,1,0,0, 4'b0000));

        repeat (2) @(negedge clk);
        #1;
        check("reset_flags", {4'd0, Flags}, 8'd0);
        check("reset_exec", 8'(ExecCount), 8'd0);
        check("reset_skip", 8'(SkipCount), 8'd0);
        reset = 1'b0;

        // Mid-cycle reset from Flags = 1111 with a nonzero counter.
        apply_model(mks(1,0,4'hE,4'b1111,2'b11,0,0,0,0,0));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        mflags = '0; mexec = '0; mskip = '0;
        check("async_rst_flags", {4'd0, Flags}, 8'd0);
        check("async_rst_exec", 8'(ExecCount), 8'd0);
        Valid = 1'b1; Stall = 1'b0; FlagW = 2'b00; Cond = 4'h0;
        #1;
        check("rst_eq", {7'd0, CondEx}, 8'd0);
        Cond = 4'h1;
        #1;
        check("rst_ne", {7'd0, CondEx}, 8'd1);
        @(negedge clk);
        reset = 1'b0;
        Valid = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i].s, tbl[i].r);

        for (int i = 0; i < 150; i++) begin
            s.valid = ($urandom_range(0, 3) != 0);
            s.stall = ($urandom_range(0, 3) == 0);
            s.cond  = 4'($urandom_range(0, 15));
            s.alu   = 4'($urandom_range(0, 15));
            s.fw    = 2'($urandom_range(0, 3));
            s.pcs   = 1'($urandom_range(0, 1));
            s.regw  = 1'($urandom_range(0, 1));
            s.memw  = 1'($urandom_range(0, 1));
            s.nowr  = 1'($urandom_range(0, 1));
            s.clr   = ($urandom_range(0, 15) == 0);
            apply_model(s);
        end

        // Counter saturation and clear priority.
        apply_model(mks(1,0,4'hE,4'b0000,2'b00,0,0,0,0,1));
        for (int i = 0; i < 17; i++) apply_model(mks(1,0,4'hE,4'b0000,2'b00,0,1,0,0,0));
        check("exec_saturated", 8'(ExecCount), CNT_ON ? 8'd15 : 8'd0);
        apply_model(mks(1,0,4'hE,4'b0000,2'b00,0,1,0,0,1));
        check("exec_cleared", 8'(ExecCount), 8'd0);
        for (int i = 0; i < 17; i++) apply_model(mks(1,0,4'hF,4'b0000,2'b00,0,0,0,0,0));
        check("skip_saturated", 8'(SkipCount), CNT_ON ? 8'd15 : 8'd0);
        apply_model(mks(1,1,4'hE,4'b1111,2'b11,0,1,0,0,1));
        check("stall_clr_skip", 8'(SkipCount), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
